// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// and the illegal-opcode test.
package alu_req_arbiter_pkg;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_NOT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Codes above AND (6, 7) have no ALU meaning and are answered with an error.
  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_AND;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the two request channels, the ALU drive/return path and the
// tagged response channel seen by the arbiter.
interface alu_req_arbiter_if #(
  parameter int N = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_op;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_op;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_cin;

  logic [2:0]   alu_op;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cin;
  logic [N-1:0] alu_result;
  logic         alu_cout;

  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [N-1:0] resp_data;
  logic         resp_cout;
  logic         resp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
    input  alu_result, alu_cout, resp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b, alu_cin,
    output resp_valid, resp_id, resp_data, resp_cout, resp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_cin,
    output req1_valid, req1_op, req1_a, req1_b, req1_cin,
    output alu_result, alu_cout, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b, alu_cin,
    input  resp_valid, resp_id, resp_data, resp_cout, resp_err
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two valid/ready requesters; one operation
// in flight at a time, result returned on an ID-tagged response channel.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int N       = 32,
  parameter int ALU_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  alu_req_arbiter_if.slave  bus
);

  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             id_q;
  logic [CNT_W-1:0] cnt;

  logic [1:0]   req;
  logic [1:0]   gnt;
  logic         idle;
  logic         accept;
  logic         acc_id;
  logic         acc_ill;
  logic         lat_done;
  logic [2:0]   sel_op;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic         sel_cin;

  assign req = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign idle     = (state == S_IDLE);
  assign accept   = idle & (|gnt);
  assign acc_id   = gnt[1];
  assign sel_op   = acc_id ? bus.req1_op  : bus.req0_op;
  assign sel_a    = acc_id ? bus.req1_a   : bus.req0_a;
  assign sel_b    = acc_id ? bus.req1_b   : bus.req0_b;
  assign sel_cin  = acc_id ? bus.req1_cin : bus.req0_cin;
  assign acc_ill  = op_illegal(sel_op);
  assign lat_done = (cnt == CNT_W'(ALU_LAT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; illegal ops skip EXEC so the ALU is never issued
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = acc_ill ? S_RESP : S_EXEC;
      S_EXEC:  if (lat_done) state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.req0_ready = idle & gnt[0];
    bus.req1_ready = idle & gnt[1];
    bus.resp_valid = (state == S_RESP);
  end

  // Arbitration pointer, ALU operand hold registers and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= 1'b0;
      id_q          <= 1'b0;
      cnt           <= '0;
      bus.alu_op    <= 3'd0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_cin   <= 1'b0;
      bus.resp_id   <= 1'b0;
      bus.resp_data <= '0;
      bus.resp_cout <= 1'b0;
      bus.resp_err  <= 1'b0;
    end else if (accept) begin
      id_q   <= acc_id;
      rr_ptr <= ~acc_id;
      if (acc_ill) begin
        bus.resp_id   <= acc_id;
        bus.resp_data <= '0;
        bus.resp_cout <= 1'b0;
        bus.resp_err  <= 1'b1;
      end else begin
        bus.alu_op  <= sel_op;
        bus.alu_a   <= sel_a;
        bus.alu_b   <= sel_b;
        bus.alu_cin <= sel_cin;
        cnt         <= '0;
      end
    end else if (state == S_EXEC) begin
      if (lat_done) begin
        bus.resp_id   <= id_q;
        bus.resp_data <= bus.alu_result;
        bus.resp_cout <= bus.alu_cout;
        bus.resp_err  <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: registered ALU model, directed vector table,
// hand-written corner sequences and a randomized scoreboard run.
module tb_alu_req_arbiter;

  localparam int N       = 32;
  localparam int ALU_LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_req_arbiter_if #(.N(N)) bus ();

  alu_req_arbiter #(.N(N), .ALU_LAT(ALU_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ALU behaviour: {cout, result}; subtract is a + ~b + cin
  function automatic logic [N:0] alu_calc(input logic [2:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic cin);
    case (op)
      3'd0:    return {1'b0, a};
      3'd1:    return {1'b0, ~a};
      3'd2:    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      3'd3:    return {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, cin};
      3'd4:    return {1'b0, a | b};
      3'd5:    return {1'b0, a & b};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk)
    {bus.alu_cout, bus.alu_result} <= alu_calc(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);

  typedef struct {
    logic         id;
    logic [N-1:0] data;
    logic         cout;
    logic         err;
  } exp_t;

  function automatic exp_t ref_resp(input logic id, input logic [2:0] op,
                                    input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic cin);
    exp_t e;
    logic [N:0] r;
    r      = alu_calc(op, a, b, cin);
    e.id   = id;
    e.err  = (op > 3'd5);
    e.data = e.err ? '0 : r[N-1:0];
    e.cout = e.err ? 1'b0 : r[N];
    return e;
  endfunction

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input logic s, input logic v, input logic [2:0] op,
                         input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    if (!s) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_resp"}, {bus.resp_valid, bus.resp_id, bus.resp_cout, bus.resp_err,
                           bus.req0_ready, bus.req1_ready}, 64'd0);
    check({tag, "_resp_data"}, bus.resp_data, 64'd0);
    check({tag, "_alu_ctl"}, {bus.alu_op, bus.alu_cin}, 64'd0);
    check({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
  endtask

  task automatic wait_resp(input string name, output bit got);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin got = 1; break; end
    end
    check(name, got, 1);
  endtask

  typedef struct {
    logic         sel;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] exp_data;
    logic         exp_cout;
    logic         exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input vec_t v, input int idx);
    logic [2:0]   prev_op;
    logic [N-1:0] prev_a, prev_b;
    logic         prev_cin;
    int           acc_cyc;
    bit           got;
    prev_op = bus.alu_op; prev_a = bus.alu_a; prev_b = bus.alu_b; prev_cin = bus.alu_cin;
    @(posedge clk); #1;
    set_req(v.sel, 1'b1, v.op, v.a, v.b, v.cin);
    bus.resp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (v.sel ? bus.req1_ready : bus.req0_ready) begin got = 1; break; end
    end
    check($sformatf("vec%0d_ready", idx), got, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    set_req(v.sel, 1'b0, 3'd0, '0, '0, 1'b0);
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin got = 1; break; end
      check($sformatf("vec%0d_exec_hold", idx),
            {bus.alu_op, bus.alu_cin, bus.req0_ready, bus.req1_ready}, {v.op, v.cin, 2'b00});
      check($sformatf("vec%0d_exec_ab", idx), {bus.alu_a, bus.alu_b}, {v.a, v.b});
    end
    check($sformatf("vec%0d_latency", idx), cyc - acc_cyc, v.exp_err ? 0 : ALU_LAT + 1);
    check($sformatf("vec%0d_data", idx), bus.resp_data, v.exp_data);
    check($sformatf("vec%0d_flags", idx), {bus.resp_id, bus.resp_cout, bus.resp_err},
          {v.sel, v.exp_cout, v.exp_err});
    if (v.exp_err)
      check($sformatf("vec%0d_alu_unchanged", idx), {bus.alu_op, bus.alu_cin, bus.alu_a, bus.alu_b},
            {prev_op, prev_cin, prev_a, prev_b});
    @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d_after", idx), {bus.resp_valid, bus.req0_ready, bus.req1_ready}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit         got;
    int         grants [$];
    exp_t       sb [$];
    exp_t       e;
    bit         pend [2];
    bit         acc [2];
    logic [2:0] p_op [2];
    logic [N-1:0] p_a [2];
    logic [N-1:0] p_b [2];
    logic       p_cin [2];
    bit         busy;
    logic       model_ptr;
    logic [1:0] exp_gnt;
    int         n_resp;
    int         bad;
    logic [N-1:0] held_data;

    set_req(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    bus.resp_ready = 1'b0;
    #2 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", {bus.resp_valid, bus.req0_ready, bus.req1_ready}, 0);

    // directed vector table
    vecs[0]  = '{1'b0, 3'd2, 32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd3, 32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd3, 32'd5,        32'd3,        1'b1, 32'd2,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'd0,        1'b1, 32'd0,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, 3'd4, 32'h000000F0, 32'h0000000F, 1'b0, 32'h000000FF, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd5, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd6, 32'h11111111, 32'h22222222, 1'b1, 32'd0,        1'b0, 1'b1};
    vecs[8]  = '{1'b1, 3'd7, 32'd123,      32'd456,      1'b0, 32'd0,        1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'd1, 32'h12345678, 32'd0,        1'b1, 32'hEDCBA987, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 32'hDEADBEEF, 32'h1,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // tie from reset: grants must alternate 0,1,0,1
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(1'b0, 1'b1, 3'd0, 32'hA, 32'd0, 1'b0);
    set_req(1'b1, 1'b1, 3'd1, 32'd0, 32'd0, 1'b0);
    bus.resp_ready = 1'b1;
    n_resp = 0; bad = 0;
    for (int k = 0; k < 40 && n_resp < 4; k++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) bad++;
      if (bus.req0_ready || bus.req1_ready) grants.push_back(int'(bus.req1_ready));
      if (bus.resp_valid) begin
        n_resp++;
        check("tie_resp_data", bus.resp_data, bus.resp_id ? 32'hFFFFFFFF : 32'h0000000A);
        check("tie_resp_id", bus.resp_id, n_resp[0] ? 1'b0 : 1'b1);
      end
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    check("tie_two_readys", bad, 0);
    check("tie_grant_count", grants.size(), 4);
    while (grants.size() < 4) grants.push_back(-1);
    check("tie_grant_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]},
          8'b00_01_00_01);

    // backpressure with req1 waiting
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd5, 32'h0000F0F0, 32'h0000FF00, 1'b0);
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("bp_ready0", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    set_req(1'b1, 1'b1, 3'd0, 32'h55, 32'd0, 1'b0);
    wait_resp("bp_resp_seen", got);
    held_data = 32'h0000F000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_ctl", {bus.resp_valid, bus.resp_id, bus.resp_cout, bus.resp_err,
                            bus.req0_ready, bus.req1_ready}, 6'b100000);
      check("bp_hold_data", bus.resp_data, held_data);
    end
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_cycle", {bus.resp_valid, bus.req0_ready, bus.req1_ready}, 3'b100);
    @(negedge clk);
    check("bp_after_hs", {bus.resp_valid, bus.req0_ready, bus.req1_ready}, 3'b001);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    wait_resp("bp_req1_resp_seen", got);
    check("bp_req1_resp", {bus.resp_id, bus.resp_err, bus.resp_data}, {1'b1, 1'b0, 32'h55});
    @(posedge clk);

    // reset during EXEC after a req0 accept (pointer would favour req1)
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd2, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.resp_valid) bad++;
    end
    check("midrst_no_stale", bad, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd0, 32'd7, 32'd0, 1'b0);
    set_req(1'b1, 1'b1, 3'd0, 32'd9, 32'd0, 1'b0);
    @(negedge clk);
    check("midrst_ptr0", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    wait_resp("midrst_resp_seen", got);
    check("midrst_resp", {bus.resp_id, bus.resp_data}, {1'b0, 32'd7});

    // randomized traffic against a transaction-level scoreboard
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    busy = 0; model_ptr = 1'b0;
    for (int s = 0; s < 2; s++) begin pend[s] = 0; acc[s] = 0; end
    for (int it = 0; it < 640; it++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin pend[s] = 0; acc[s] = 0; end
        if (!pend[s] && it < 560 && $urandom_range(0, 2) == 0) begin
          pend[s]  = 1;
          p_op[s]  = 3'($urandom_range(0, 7));
          p_a[s]   = $urandom;
          p_b[s]   = $urandom;
          p_cin[s] = 1'($urandom_range(0, 1));
        end
        set_req(s[0], pend[s], p_op[s], p_a[s], p_b[s], p_cin[s]);
      end
      bus.resp_ready = (it >= 560) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_gnt = 2'b00;
      if (!busy) begin
        if (pend[0] && pend[1]) exp_gnt = model_ptr ? 2'b10 : 2'b01;
        else                    exp_gnt = {pend[1], pend[0]};
      end
      check("rnd_grant", {bus.req1_ready, bus.req0_ready}, exp_gnt);
      if (exp_gnt != 2'b00) begin
        sb.push_back(ref_resp(exp_gnt[1], p_op[exp_gnt[1]], p_a[exp_gnt[1]],
                              p_b[exp_gnt[1]], p_cin[exp_gnt[1]]));
        model_ptr    = ~exp_gnt[1];
        acc[exp_gnt[1]] = 1;
        busy         = 1;
      end else if (bus.resp_valid && bus.resp_ready) begin
        check("rnd_resp_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rnd_resp", {bus.resp_id, bus.resp_cout, bus.resp_err, bus.resp_data},
                {e.id, e.cout, e.err, e.data});
        end
        busy = 0;
      end
    end
    check("rnd_drained", {busy, 31'(sb.size())}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
